// File: rtl/dsp_pkg.sv
// Shared types, register map and lane geometry for the DSP dispatcher.
package dsp_pkg;
  localparam int N_LANES = 8;
  localparam int DATA_W  = 32;

  localparam logic [4:0] ADDR_A      = 5'h00;
  localparam logic [4:0] ADDR_B      = 5'h08;
  localparam logic [4:0] ADDR_RES    = 5'h10;
  localparam logic [4:0] ADDR_CTRL   = 5'h18;
  localparam logic [4:0] ADDR_STATUS = 5'h19;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_FIR = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;
endpackage

// File: rtl/dsp_dispatcher_regs.sv
// Register file for the dispatcher: operand/result banks, CTRL/STATUS,
// bus decode and the registered read mux.
module dsp_dispatcher_regs #(
  parameter int N_LANES = dsp_pkg::N_LANES,
  parameter int DATA_W  = dsp_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [4:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_rvalid,
  input  logic              busy,
  input  logic              capture,
  input  logic              set_err,
  input  logic [DATA_W-1:0] dsp_result [N_LANES],
  output logic [DATA_W-1:0] a [N_LANES],
  output logic [DATA_W-1:0] b [N_LANES],
  output logic [1:0]        op,
  output logic              go,
  output logic              irq
);
  import dsp_pkg::*;

  logic [DATA_W-1:0] res [N_LANES];
  op_t         op_q;
  logic        irq_en, done_flag, err_flag, wr_reject;
  logic [2:0]  idx;
  logic        wr_a, wr_b, wr_ctrl, wr_status, reject;
  logic [31:0] rd_mux;

  assign idx       = bus_addr[2:0];
  assign wr_a      = bus_we && (bus_addr[4:3] == ADDR_A[4:3]);
  assign wr_b      = bus_we && (bus_addr[4:3] == ADDR_B[4:3]);
  assign wr_ctrl   = bus_we && (bus_addr == ADDR_CTRL);
  assign wr_status = bus_we && (bus_addr == ADDR_STATUS);
  assign reject    = busy && (wr_a || wr_b || wr_ctrl);
  assign go        = wr_ctrl && !busy && bus_wdata[0];
  assign op        = op_q;
  assign irq       = irq_en && (done_flag || err_flag);

  always_comb begin
    rd_mux = '0;
    case (bus_addr[4:3])
      ADDR_A[4:3]:   rd_mux = 32'(a[idx]);
      ADDR_B[4:3]:   rd_mux = 32'(b[idx]);
      ADDR_RES[4:3]: rd_mux = 32'(res[idx]);
      default: begin
        if (bus_addr == ADDR_CTRL)
          rd_mux = {28'd0, irq_en, op_q, 1'b0};
        else if (bus_addr == ADDR_STATUS)
          rd_mux = {28'd0, wr_reject, err_flag, done_flag, busy};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_LANES; i++) begin
        a[i]   <= '0;
        b[i]   <= '0;
        res[i] <= '0;
      end
      op_q       <= OP_ADD;
      irq_en     <= 1'b0;
      done_flag  <= 1'b0;
      err_flag   <= 1'b0;
      wr_reject  <= 1'b0;
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      if (wr_a && !busy) a[idx] <= DATA_W'(bus_wdata);
      if (wr_b && !busy) b[idx] <= DATA_W'(bus_wdata);
      if (wr_ctrl && !busy) begin
        op_q   <= op_t'(bus_wdata[2:1]);
        irq_en <= bus_wdata[3];
      end
      if (capture)
        for (int i = 0; i < N_LANES; i++) res[i] <= dsp_result[i];
      // Hardware set beats a same-cycle write-1-to-clear; a new GO clears old completion state.
      done_flag  <= capture || (done_flag && !(wr_status && bus_wdata[1]) && !go);
      err_flag   <= set_err || (err_flag && !(wr_status && bus_wdata[2]) && !go);
      wr_reject  <= reject  || (wr_reject && !(wr_status && bus_wdata[3]));
      // Registered read sees pre-write state, so a same-cycle write is not visible yet.
      bus_rvalid <= bus_re;
      bus_rdata  <= bus_re ? rd_mux : '0;
    end
  end
endmodule

// File: rtl/dsp_dispatcher.sv
// Initiator side of the DSP start/done handshake: register file plus the
// IDLE/START/WAIT/CAPTURE sequencer with a done timeout.
module dsp_dispatcher #(
  parameter int N_LANES = dsp_pkg::N_LANES,
  parameter int DATA_W  = dsp_pkg::DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [4:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_rvalid,
  output logic              irq,
  output logic              dsp_start,
  output logic [1:0]        dsp_operation,
  output logic [DATA_W-1:0] dsp_A [N_LANES],
  output logic [DATA_W-1:0] dsp_B [N_LANES],
  input  logic [DATA_W-1:0] dsp_result [N_LANES],
  input  logic              dsp_done
);
  import dsp_pkg::*;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy, go, capture, set_err;

  assign busy = (state != IDLE);

  dsp_dispatcher_regs #(
    .N_LANES (N_LANES),
    .DATA_W  (DATA_W)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .busy       (busy),
    .capture    (capture),
    .set_err    (set_err),
    .dsp_result (dsp_result),
    .a          (dsp_A),
    .b          (dsp_B),
    .op         (dsp_operation),
    .go         (go),
    .irq        (irq)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // dsp_done outside WAIT is ignored simply because only WAIT looks at it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dsp_start = 1'b0;
    capture   = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE:  if (go) state_nxt = START;
      START: begin
        dsp_start = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (dsp_done) begin
          state_nxt = CAPTURE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          set_err   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
